// File: rtl/rdm_pkg.sv
// rtl/rdm_pkg.sv - shared types and constants for the RDM combine scheduler
// Purpose: one-hot scheduler state encoding, field widths, the layout of a
// per-user config entry, and the e01-to-buffer-word helper.
// Ports: none (package).
package rdm_pkg;

  localparam int USER_NUM   = 16;
  localparam int IDX_W      = 4;
  localparam int E01_W      = 14;
  localparam int NCB_W      = 16;
  localparam int QM_W       = 2;
  localparam int WORD_SHIFT = 4;
  localparam int SUM_W      = E01_W + 1;

  typedef enum logic [6:0] {
    S_IDLE      = 7'b0000001,
    S_SCAN      = 7'b0000010,
    S_LAUNCH    = 7'b0000100,
    S_WAIT_COMP = 7'b0001000,
    S_GAP       = 7'b0010000,
    S_FLUSH     = 7'b0100000,
    S_DONE      = 7'b1000000
  } state_e;

  typedef struct packed {
    logic [NCB_W-1:0] ncb;
    logic [E01_W-1:0] e01;
  } cfg_entry_t;

  // Input-buffer words occupied by a user's e01 soft bits, rounded up.
  function automatic logic [NCB_W-1:0] words_of(input logic [E01_W-1:0] e01);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, e01} + SUM_W'((1 << WORD_SHIFT) - 1);
    return NCB_W'(sum >> WORD_SHIFT);
  endfunction

endpackage

// File: rtl/rdm_combine_scheduler_if.sv
// rtl/rdm_combine_scheduler_if.sv - handshake bundle between scheduler and RDM FSM
// Purpose: groups the per-user launch handshake toward the RDM FSM.
// Signals: request pulse, user index, latched E0/1/Ncb/Qm, buffer base,
//          completion back from the RDM FSM, active-low RDM FSM reset.
// Modports: master = scheduler side, slave = RDM FSM side.
interface rdm_combine_scheduler_if;
  import rdm_pkg::*;

  logic                  o_Combine_process_request;
  logic [IDX_W-1:0]      o_Combine_user_index;
  logic [E01_W-1:0]      o_Current_Combine_E01_Size;
  logic [NCB_W-1:0]      o_Current_Combine_Ncb_Size;
  logic [QM_W-1:0]       o_user_qm;
  logic [15:0]           o_Input_Buffer_Base_Address;
  logic                  i_RDM_Data_Comp;
  logic                  o_rx_fsm_rstn;

  modport master (
    output o_Combine_process_request, o_Combine_user_index,
           o_Current_Combine_E01_Size, o_Current_Combine_Ncb_Size,
           o_user_qm, o_Input_Buffer_Base_Address, o_rx_fsm_rstn,
    input  i_RDM_Data_Comp
  );

  modport slave (
    input  o_Combine_process_request, o_Combine_user_index,
           o_Current_Combine_E01_Size, o_Current_Combine_Ncb_Size,
           o_user_qm, o_Input_Buffer_Base_Address, o_rx_fsm_rstn,
    output i_RDM_Data_Comp
  );

endinterface

// File: rtl/rdm_user_cfg_table.sv
// rtl/rdm_user_cfg_table.sv - per-user {ncb, e01} register file
// Purpose: USER_NUM-entry table, one synchronous write port and one
// combinational read port. Contents survive reset by design.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr/rd_data read port.
module rdm_user_cfg_table
  import rdm_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  cfg_entry_t       wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output cfg_entry_t       rd_data
);

  cfg_entry_t mem_q [USER_NUM];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read sees the pre-write contents during a same-cycle write.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/rdm_combine_scheduler.sv
// rtl/rdm_combine_scheduler.sv - per-user combine sequencer for the RDM read-out path
// Purpose: on i_start walks users 0..15, launches each valid one toward the
// RDM FSM, accumulates the input-buffer base, and aborts hung transfers.
// Ports: i_core_clk/i_rx_rst clock and sync active-high reset; i_cfg_wr_*
//        config table write; i_users_valid/i_users_qm per-user mask and Qm;
//        i_start/o_busy/o_done pass control; o_err_timeout/o_err_user
//        timeout status; rdm = handshake bundle to the RDM FSM.
module rdm_combine_scheduler #(
  parameter int          USER_NUM    = 16,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4095
) (
  input  logic        i_core_clk,
  input  logic        i_rx_rst,
  input  logic        i_cfg_wr_en,
  input  logic [3:0]  i_cfg_wr_user,
  input  logic [13:0] i_cfg_wr_e01,
  input  logic [15:0] i_cfg_wr_ncb,
  input  logic [15:0] i_users_valid,
  input  logic [31:0] i_users_qm,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err_timeout,
  output logic [3:0]  o_err_user,
  rdm_combine_scheduler_if.master rdm
);
  import rdm_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(USER_NUM - 1);

  state_e           state_q, state_d;
  logic [15:0]      mask_q, mask_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             gap_q, gap_d;
  logic [E01_W-1:0] e01_q, e01_d;
  logic [NCB_W-1:0] ncb_q, ncb_d;
  logic [QM_W-1:0]  qm_q, qm_d;
  logic [15:0]      base_q, base_d;
  logic             err_to_q, err_to_d;
  logic [IDX_W-1:0] err_user_q, err_user_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             req_q, req_d;
  logic             rstn_q, rstn_d;
  logic             last_idx;

  cfg_entry_t wr_entry, rd_entry;

  assign wr_entry.ncb = i_cfg_wr_ncb;
  assign wr_entry.e01 = i_cfg_wr_e01;

  rdm_user_cfg_table u_cfg_table (
    .clk     (i_core_clk),
    .wr_en   (i_cfg_wr_en),
    .wr_addr (i_cfg_wr_user),
    .wr_data (wr_entry),
    .rd_addr (idx_q),
    .rd_data (rd_entry)
  );

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    e01_d      = e01_q;
    ncb_d      = ncb_q;
    qm_d       = qm_q;
    base_d     = base_q;
    err_to_d   = err_to_q;
    err_user_d = err_user_q;
    last_idx   = (idx_q == LAST_IDX);

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mask_d   = i_users_valid;
          idx_d    = '0;
          base_d   = '0;
          err_to_d = 1'b0;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (mask_q[idx_q]) begin
          // Latch on entry to LAUNCH so the values are already on the
          // outputs in the same cycle as the request pulse.
          e01_d   = rd_entry.e01;
          ncb_d   = rd_entry.ncb;
          qm_d    = i_users_qm[{idx_q, 1'b0} +: QM_W];
          state_d = S_LAUNCH;
        end else if (last_idx) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT_COMP;
      end
      S_WAIT_COMP: begin
        // Completion is tested first so it wins over a same-cycle timeout.
        // 16-bit add wraps exactly like the truncated 17-bit sum.
        if (rdm.i_RDM_Data_Comp) begin
          base_d  = base_q + words_of(e01_q);
          gap_d   = 1'b0;
          state_d = S_GAP;
        end else if (cnt_q + 16'd1 == TIMEOUT_CYC) begin
          err_to_d   = 1'b1;
          err_user_d = idx_q;
          state_d    = S_FLUSH;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (!gap_q) begin
          gap_d = 1'b1;
        end else if (last_idx) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SCAN;
        end
      end
      S_FLUSH: begin
        if (last_idx) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of the next-state decode.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    req_d  = (state_d == S_LAUNCH);
    rstn_d = (state_d != S_FLUSH);
  end

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= 1'b0;
      e01_q      <= '0;
      ncb_q      <= '0;
      qm_q       <= '0;
      base_q     <= '0;
      err_to_q   <= 1'b0;
      err_user_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      rstn_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      e01_q      <= e01_d;
      ncb_q      <= ncb_d;
      qm_q       <= qm_d;
      base_q     <= base_d;
      err_to_q   <= err_to_d;
      err_user_q <= err_user_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      req_q      <= req_d;
      rstn_q     <= rstn_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err_timeout = err_to_q;
  assign o_err_user    = err_user_q;

  assign rdm.o_Combine_process_request   = req_q;
  assign rdm.o_Combine_user_index        = idx_q;
  assign rdm.o_Current_Combine_E01_Size  = e01_q;
  assign rdm.o_Current_Combine_Ncb_Size  = ncb_q;
  assign rdm.o_user_qm                   = qm_q;
  assign rdm.o_Input_Buffer_Base_Address = base_q;
  assign rdm.o_rx_fsm_rstn               = rstn_q;

endmodule

// File: tb/tb_rdm_combine_scheduler.sv
// tb/tb_rdm_combine_scheduler.sv - self-checking bench for rdm_combine_scheduler
module tb_rdm_combine_scheduler;

  localparam logic [15:0] TO   = 16'd20;
  localparam int          TO_I = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr_en;
  logic [3:0]  cfg_wr_user;
  logic [13:0] cfg_wr_e01;
  logic [15:0] cfg_wr_ncb;
  logic [15:0] users_valid;
  logic [31:0] users_qm;
  logic        start;
  logic        busy, done, err_to;
  logic [3:0]  err_user;

  rdm_combine_scheduler_if rdm_if ();

  rdm_combine_scheduler #(.USER_NUM(16), .TIMEOUT_CYC(TO)) dut (
    .i_core_clk    (clk),
    .i_rx_rst      (rst),
    .i_cfg_wr_en   (cfg_wr_en),
    .i_cfg_wr_user (cfg_wr_user),
    .i_cfg_wr_e01  (cfg_wr_e01),
    .i_cfg_wr_ncb  (cfg_wr_ncb),
    .i_users_valid (users_valid),
    .i_users_qm    (users_qm),
    .i_start       (start),
    .o_busy        (busy),
    .o_done        (done),
    .o_err_timeout (err_to),
    .o_err_user    (err_user),
    .rdm           (rdm_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int done_cnt = 0, flush_cnt = 0, done_cyc = 0, flush_cyc = 0;
  int log_user[$], log_e01[$], log_ncb[$], log_qm[$], log_base[$], log_cyc[$];
  int delay_tab[16];
  int m_e01[16], m_ncb[16];
  int m_err_user = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdm_if.o_Combine_process_request === 1'b1) begin
      log_user.push_back(int'(rdm_if.o_Combine_user_index));
      log_e01.push_back(int'(rdm_if.o_Current_Combine_E01_Size));
      log_ncb.push_back(int'(rdm_if.o_Current_Combine_Ncb_Size));
      log_qm.push_back(int'(rdm_if.o_user_qm));
      log_base.push_back(int'(rdm_if.o_Input_Buffer_Base_Address));
      log_cyc.push_back(cyc);
    end
    if (rdm_if.o_rx_fsm_rstn === 1'b0) begin
      flush_cnt++;
      flush_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // RDM FSM stand-in: completes d cycles after each request, never if d <= 0.
  initial begin
    int d;
    rdm_if.i_RDM_Data_Comp = 1'b0;
    forever begin
      @(negedge clk);
      if (rdm_if.o_Combine_process_request === 1'b1) begin
        d = delay_tab[rdm_if.o_Combine_user_index];
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1 rdm_if.i_RDM_Data_Comp = 1'b1;
          @(posedge clk);
          #1 rdm_if.i_RDM_Data_Comp = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int u, input int e, input int n);
    cfg_wr_en   = 1'b1;
    cfg_wr_user = 4'(u);
    cfg_wr_e01  = 14'(e);
    cfg_wr_ncb  = 16'(n);
    tick();
    cfg_wr_en   = 1'b0;
    m_e01[u]    = e & 'h3fff;
    m_ncb[u]    = n & 'hffff;
  endtask

  task automatic randomize_table();
    for (int u = 0; u < 16; u++) cfg_write(u, int'($urandom_range(0, 16383)), int'($urandom_range(0, 65535)));
  endtask

  task automatic random_delays();
    for (int u = 0; u < 16; u++)
      delay_tab[u] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, TO_I));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".busy"}, busy, 0);
    check({name, ".done"}, done, 0);
    check({name, ".req"}, rdm_if.o_Combine_process_request, 0);
    check({name, ".err_to"}, err_to, 0);
    check({name, ".err_user"}, err_user, 0);
    check({name, ".index"}, rdm_if.o_Combine_user_index, 0);
    check({name, ".e01"}, rdm_if.o_Current_Combine_E01_Size, 0);
    check({name, ".ncb"}, rdm_if.o_Current_Combine_Ncb_Size, 0);
    check({name, ".qm"}, rdm_if.o_user_qm, 0);
    check({name, ".base"}, rdm_if.o_Input_Buffer_Base_Address, 0);
    check({name, ".rstn"}, rdm_if.o_rx_fsm_rstn, 1);
  endtask

  // Starts one pass and checks every launch against the expected walk.
  task automatic run_and_check(input string name, input logic [15:0] mask, input logic [31:0] qm);
    int r0, d0, f0, st, n, j, exp_flush, first;
    logic [15:0] base;
    r0 = log_user.size();
    d0 = done_cnt;
    f0 = flush_cnt;
    users_valid = mask;
    users_qm    = qm;
    start = 1'b1;
    st    = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2000 && done_cnt == d0; i++) tick();
    check({name, ".done_once"}, done_cnt - d0, 1);
    check({name, ".busy_after_done"}, busy, 0);
    n = log_user.size() - r0;
    base = 16'h0;
    j = 0;
    exp_flush = 0;
    first = -1;
    for (int u = 0; u < 16; u++) begin
      if (mask[u]) begin
        if (first < 0) first = u;
        if (j < n) begin
          check($sformatf("%s.l%0d.user", name, j), log_user[r0 + j], u);
          check($sformatf("%s.l%0d.e01", name, j), log_e01[r0 + j], m_e01[u]);
          check($sformatf("%s.l%0d.ncb", name, j), log_ncb[r0 + j], m_ncb[u]);
          check($sformatf("%s.l%0d.qm", name, j), log_qm[r0 + j], (qm >> (2 * u)) & 3);
          check($sformatf("%s.l%0d.base", name, j), log_base[r0 + j], base);
        end
        j++;
        if (delay_tab[u] > 0) base = base + 16'((m_e01[u] + 15) >> 4);
        else begin
          exp_flush++;
          m_err_user = u;
        end
      end
    end
    check({name, ".n_requests"}, n, j);
    check({name, ".n_flush"}, flush_cnt - f0, exp_flush);
    check({name, ".err_timeout"}, err_to, (exp_flush > 0) ? 1 : 0);
    check({name, ".err_user"}, err_user, m_err_user);
    check({name, ".final_base"}, rdm_if.o_Input_Buffer_Base_Address, base);
    if (first >= 0 && n > 0) check({name, ".first_req_lat"}, log_cyc[r0] - st, first + 2);
    else if (mask == 16'h0) check({name, ".done_lat"}, done_cyc - st, 17);
  endtask

  initial begin
    int r0, d0, f0, e_old, n_old, e_new, n_new, lat;
    rst = 1'b1;
    cfg_wr_en = 1'b0; cfg_wr_user = '0; cfg_wr_e01 = '0; cfg_wr_ncb = '0;
    users_valid = '0; users_qm = '0; start = 1'b0;
    for (int u = 0; u < 16; u++) delay_tab[u] = 10;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    randomize_table();

    // Two sparse users, fixed sizes, completion 10 cycles after each request.
    cfg_write(0, 100, 16'h1234);
    cfg_write(2, 36, 16'h0abc);
    r0 = log_user.size();
    run_and_check("mask5", 16'h0005, $urandom);
    if (log_user.size() - r0 == 2) begin
      check("mask5.base_user2", log_base[r0 + 1], 7);
      check("mask5.relaunch_gap", log_cyc[r0 + 1] - log_cyc[r0], 15);
    end else check("mask5.two_requests", log_user.size() - r0, 2);

    // Empty mask walks all sixteen slots and finishes.
    run_and_check("mask0", 16'h0000, $urandom);

    // A user that never completes is flushed exactly once.
    delay_tab[1] = -1;
    run_and_check("timeout", 16'h0002, $urandom);
    lat = flush_cyc - log_cyc[log_cyc.size() - 1];
    check("timeout.flush_lat", (lat == TO_I + 1) || (lat == TO_I + 2), 1);

    // Completion in the same cycle as the timeout still counts.
    delay_tab[0] = TO_I;
    delay_tab[15] = 5;
    run_and_check("comp_on_timeout", 16'h8001, $urandom);

    // Start and config write during a pass.
    delay_tab[0] = 15;
    e_old = m_e01[0];
    n_old = m_ncb[0];
    e_new = e_old ^ 'h155;
    n_new = n_old ^ 'hffff;
    r0 = log_user.size();
    d0 = done_cnt;
    users_valid = 16'h0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && log_user.size() == r0; i++) tick();
    check("busy_start.req_seen", log_user.size() - r0, 1);
    tick();
    tick();
    start = 1'b1;
    cfg_wr_en = 1'b1; cfg_wr_user = 4'd0; cfg_wr_e01 = 14'(e_new); cfg_wr_ncb = 16'(n_new);
    tick();
    start = 1'b0;
    cfg_wr_en = 1'b0;
    m_e01[0] = e_new;
    m_ncb[0] = n_new;
    tick();
    check("busy_start.e01_held", rdm_if.o_Current_Combine_E01_Size, e_old);
    check("busy_start.ncb_held", rdm_if.o_Current_Combine_Ncb_Size, n_old);
    check("busy_start.busy", busy, 1);
    for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
    check("busy_start.done_once", done_cnt - d0, 1);
    repeat (5) tick();
    check("busy_start.no_second_pass", log_user.size() - r0, 1);
    check("busy_start.idle", busy, 0);
    run_and_check("after_write", 16'h0001, $urandom);

    // Reset in the middle of WAIT_COMP.
    for (int u = 0; u < 16; u++) delay_tab[u] = -1;
    r0 = log_user.size();
    f0 = flush_cnt;
    users_valid = 16'h0003;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && log_user.size() == r0; i++) tick();
    check("midrst.req_seen", log_user.size() - r0, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    m_err_user = 0;
    tick();
    check("midrst.no_rstn_pulse", flush_cnt - f0, 0);
    random_delays();
    run_and_check("post_rst", 16'($urandom), $urandom);

    // Randomized passes.
    for (int p = 0; p < 4; p++) begin
      randomize_table();
      random_delays();
      run_and_check($sformatf("rand%0d", p), 16'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
